rx_byte_assembler: RTL and testbench
====================================

RX_BYTE_ASSEMBLER -- requirements
Module: rx_byte_assembler

Interface
REQ-001 The block SHALL have parameter CNT_W, default 11, width of the received-byte counter.
REQ-002 The block SHALL have port Rx_Byte_Assembler_Clk  input  1  bit-rate clock; all sequential logic on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port Syn_In  input  1  sync-detected level from the sync detector; rising edge marks packet start.
REQ-005 The block SHALL have port SE0_In  input  1  end-of-packet indication from the sync detector.
REQ-006 The block SHALL have port Rx_Byte_Assembler_Data_In  input  1  NRZI-decoded serial bit, one bit per clock.
REQ-007 The block SHALL have port Byte_Out  output  8  assembled byte.
REQ-008 The block SHALL have port Byte_Valid  output  1  one-cycle pulse when Byte_Out is updated.
REQ-009 The block SHALL have port Byte_Count  output  CNT_W  bytes received in the current packet.
REQ-010 The block SHALL have port Pkt_End  output  1  one-cycle pulse on a clean end of packet.
REQ-011 The block SHALL have port Rx_Err  output  1  sticky error flag, cleared at the next packet start.

Function
REQ-012 The block SHALL implement states IDLE, RECV, ERR.
REQ-013 In IDLE, the block SHALL go to RECV on a 0->1 transition of Syn_In, clearing the shift register, bit index, ones-run counter, Byte_Count and Rx_Err; the first data bit is sampled on the next clock.
REQ-014 In RECV, each clock SHALL consume one data bit, shift it in LSB-first and increment the ones-run counter on 1, resetting it on 0.
REQ-015 After six consecutive 1s, the next bit SHALL be treated as a stuff bit: if 0, it is discarded with no shift and the run counter is cleared; if 1, the block SHALL set Rx_Err and enter ERR.
REQ-016 When the 8th non-stuff bit is shifted in, the block SHALL update Byte_Out in the same edge, pulse Byte_Valid for one cycle, increment Byte_Count and reset the bit index to 0.
REQ-017 Byte_Count SHALL saturate at 2^CNT_W-1; a further completed byte SHALL set Rx_Err and enter ERR.
REQ-018 When SE0_In is high in RECV, the block SHALL ignore that cycle's data bit and return to IDLE; it SHALL pulse Pkt_End if the bit index is 0 and Byte_Count>0, and otherwise set Rx_Err with no Pkt_End.
REQ-019 If the 8th bit and SE0_In coincide, the byte SHALL complete first, then the block SHALL evaluate end of packet with bit index 0.
REQ-020 In ERR, the block SHALL ignore data, SE0_In returns it to IDLE, and Rx_Err SHALL stay set.
REQ-021 A Syn_In rising edge seen outside IDLE SHALL be ignored.
REQ-022 Byte_Out and Byte_Count SHALL hold their values in IDLE until the next packet start.

Reset
REQ-023 While Reset is high, the block SHALL force the state to IDLE and hold Byte_Out=8'h00, Byte_Valid=0, Byte_Count=0, Pkt_End=0, Rx_Err=0, with internal counters zeroed.
REQ-024 Assertion of Reset mid-packet SHALL abort the packet immediately with no Pkt_End; after release, the block SHALL wait for a fresh Syn_In rising edge.

Configuration
REQ-025 With RX_PID_CHECK_EN defined, the first byte of each packet SHALL be checked for Byte_Out[3:0] == ~Byte_Out[7:4]; on mismatch, the block SHALL set Rx_Err and enter ERR in the same edge, while Byte_Valid still pulses.
REQ-026 Without RX_PID_CHECK_EN, the block SHALL apply no PID check and SHALL contain no PID-check logic.

Verification
REQ-027 Scenario: Syn_In rises, bits of 8'hA5 then 8'h3C LSB-first, then SE0_In -> Byte_Valid pulses with A5 and 3C, Byte_Count=2, one Pkt_End, Rx_Err=0.
REQ-028 Scenario: byte 8'hFF sent as 1,1,1,1,1,1,0(stuff),1,1 -> a single Byte_Valid with FF and bit alignment kept for the next byte.
REQ-029 Scenario: seven consecutive 1s -> Rx_Err=1, no further Byte_Valid until the next Syn_In edge, no Pkt_End at SE0.
REQ-030 Scenario: SE0_In after 12 data bits -> one byte delivered, Rx_Err=1, Pkt_End=0.
REQ-031 Scenario: Reset pulsed after 4 bits -> all outputs 0 at once; a new packet carrying 8'h69 is then received correctly.
REQ-032 Scenario: with RX_PID_CHECK_EN defined, first byte 8'h2D -> clean; first byte 8'h2C -> Rx_Err=1.

Source files
------------

// File: rtl/rx_byte_assembler.sv
// Assembles NRZI-decoded serial bits into bytes: removes stuff bits and counts bytes.
// It also flags framing errors. Define RX_PID_CHECK_EN to check the first byte of each packet as a PID.
module rx_byte_assembler #(
  parameter int CNT_W = 11
) (
  input  logic             Rx_Byte_Assembler_Clk,
  input  logic             Reset,
  input  logic             Syn_In,
  input  logic             SE0_In,
  input  logic             Rx_Byte_Assembler_Data_In,
  output logic [7:0]       Byte_Out,
  output logic             Byte_Valid,
  output logic [CNT_W-1:0] Byte_Count,
  output logic             Pkt_End,
  output logic             Rx_Err,
  output logic [1:0]       State_Dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       ones_q, ones_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pkt_end_q, pkt_end_d;
  logic             err_q, err_d;
  logic             syn_prev_q;

  logic       syn_rise;
  logic       stuff_slot;
  logic       byte_done;
  logic       take_bit;
  logic [7:0] shifted;

  assign syn_rise   = Syn_In & ~syn_prev_q;
  assign shifted    = {Rx_Byte_Assembler_Data_In, shift_q[7:1]};
  assign stuff_slot = (ones_q == 3'd6);
  assign byte_done  = (bit_idx_q == 3'd7) && !stuff_slot;
  // On an SE0 cycle the line bit is dropped, except when it would be the
  // 8th bit of a byte: that byte completes before end of packet is judged.
  assign take_bit   = !SE0_In || byte_done;

`ifdef RX_PID_CHECK_EN
  logic pid_bad;
  assign pid_bad = (count_q == '0) && (shifted[3:0] != ~shifted[7:4]);
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    ones_d    = ones_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    count_d   = count_q;
    pkt_end_d = 1'b0;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (syn_rise) begin
          state_d   = RECV;
          shift_d   = 8'h00;
          bit_idx_d = 3'd0;
          ones_d    = 3'd0;
          count_d   = '0;
          err_d     = 1'b0;
        end
      end
      RECV: begin
        if (take_bit) begin
          if (stuff_slot) begin
            if (Rx_Byte_Assembler_Data_In) begin
              err_d   = 1'b1;
              state_d = ERR;
            end else begin
              ones_d = 3'd0;
            end
          end else begin
            shift_d   = shifted;
            ones_d    = Rx_Byte_Assembler_Data_In ? ones_q + 3'd1 : 3'd0;
            bit_idx_d = bit_idx_q + 3'd1;
            if (byte_done) begin
              if (count_q == CNT_MAX) begin
                err_d   = 1'b1;
                state_d = ERR;
              end else begin
                byte_d  = shifted;
                valid_d = 1'b1;
                count_d = count_q + 1'b1;
`ifdef RX_PID_CHECK_EN
                if (pid_bad) begin
                  err_d   = 1'b1;
                  state_d = ERR;
                end
`endif
              end
            end
          end
        end
        if (SE0_In) begin
          state_d = IDLE;
          if (!err_d && bit_idx_d == 3'd0 && count_d != '0) begin
            pkt_end_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ERR: begin
        if (SE0_In) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // syn_prev_q resets high so a Syn_In level held through reset is not a start.
  always_ff @(posedge Rx_Byte_Assembler_Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_idx_q  <= 3'd0;
      ones_q     <= 3'd0;
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
      count_q    <= '0;
      pkt_end_q  <= 1'b0;
      err_q      <= 1'b0;
      syn_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      ones_q     <= ones_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      pkt_end_q  <= pkt_end_d;
      err_q      <= err_d;
      syn_prev_q <= Syn_In;
    end
  end

  assign Byte_Out   = byte_q;
  assign Byte_Valid = valid_q;
  assign Byte_Count = count_q;
  assign Pkt_End    = pkt_end_q;
  assign Rx_Err     = err_q;
  assign State_Dbg  = state_q;

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Bench for rx_byte_assembler: a stuffing encoder builds line bits from byte lists.
// Expected bytes, count, error and end-of-packet come from the packet contents.
module tb_rx_byte_assembler;
  localparam int CNT_W   = 11;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             syn;
  logic             se0;
  logic             din;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic [CNT_W-1:0] byte_count;
  logic             pkt_end;
  logic             rx_err;
  logic [1:0]       state_dbg;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] data_bytes[$];
  logic       tx_bits[$];
  int         ones_run;
  int         pkt_end_cnt;
  int         exp_cnt;
  logic       exp_err;
  int         exp_pe;

  // clock / reset
  always #5 clk = ~clk;

  rx_byte_assembler #(.CNT_W(CNT_W)) dut (
    .Rx_Byte_Assembler_Clk    (clk),
    .Reset                    (rst),
    .Syn_In                   (syn),
    .SE0_In                   (se0),
    .Rx_Byte_Assembler_Data_In(din),
    .Byte_Out                 (byte_out),
    .Byte_Valid               (byte_valid),
    .Byte_Count               (byte_count),
    .Pkt_End                  (pkt_end),
    .Rx_Err                   (rx_err),
    .State_Dbg                (state_dbg)
  );

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst && byte_valid) got_q.push_back(byte_out);
    if (!rst && pkt_end) pkt_end_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bit(input logic b);
    tx_bits.push_back(b);
    if (b) begin
      ones_run++;
      if (ones_run == 6) begin
        tx_bits.push_back(1'b0);
        ones_run = 0;
      end
    end else begin
      ones_run = 0;
    end
  endtask

  task automatic pid_fix();
`ifdef RX_PID_CHECK_EN
    if (data_bytes.size() > 0) data_bytes[0] = {data_bytes[0][7:4], ~data_bytes[0][7:4]};
`endif
  endtask

  task automatic encode(input int extra_bits, input logic [7:0] extra);
    tx_bits.delete();
    ones_run = 0;
    foreach (data_bytes[i]) begin
      for (int b = 0; b < 8; b++) push_bit(data_bytes[i][b]);
    end
    for (int b = 0; b < extra_bits; b++) push_bit(extra[b]);
  endtask

  task automatic drive(input bit coincide, input int glitch_at);
    syn = 1'b1;
    tick();
    for (int i = 0; i < int'(tx_bits.size()); i++) begin
      din = tx_bits[i];
      syn = (i == glitch_at) ? 1'b0 : 1'b1;
      se0 = coincide && (i == int'(tx_bits.size()) - 1);
      tick();
    end
    if (!coincide) begin
      syn = 1'b1;
      se0 = 1'b1;
      din = 1'($urandom_range(0, 1));
      tick();
    end
    se0 = 1'b0;
    syn = 1'b0;
    din = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_test();
    got_q.delete();
    exp_q.delete();
    pkt_end_cnt = 0;
  endtask

  task automatic load_expected(input int n);
    for (int i = 0; i < n && i < CNT_MAX; i++) exp_q.push_back(data_bytes[i]);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; syn = 1'b0; se0 = 1'b0; din = 1'b0;
    tick(); tick();
    checks++;
    if ({byte_out, byte_valid, byte_count, pkt_end, rx_err, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%h v=%b cnt=%0d pe=%b err=%b st=%0d, expected all zero",
               byte_out, byte_valid, byte_count, pkt_end, rx_err, state_dbg);
    end
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_two_bytes();
    start_test();
    data_bytes = '{8'hA5, 8'h3C};
    pid_fix();
    encode(0, 8'h00);
    load_expected(2);
    drive(1'b0, -1);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL two_bytes_data: got %0d bytes first=%h, expected %h %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0], exp_q[1]);
    end
    checks++;
    if (byte_count !== 11'd2) begin
      errors++; $display("FAIL two_bytes_count: got %0d, expected 2", byte_count);
    end
    checks++;
    if (pkt_end_cnt != 1 || rx_err !== 1'b0) begin
      errors++; $display("FAIL two_bytes_end: got pkt_end=%0d err=%b, expected 1 and 0", pkt_end_cnt, rx_err);
    end
  endtask

  task automatic test_stuffing();
    start_test();
    data_bytes = '{8'hFF, 8'h81};
    pid_fix();
    encode(0, 8'h00);
    load_expected(2);
    drive(1'b0, -1);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL stuffing_data: got %0d bytes first=%h, expected %h %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0], exp_q[1]);
    end
    checks++;
    if (pkt_end_cnt != 1 || rx_err !== 1'b0 || byte_count !== 11'd2) begin
      errors++;
      $display("FAIL stuffing_end: got pkt_end=%0d err=%b cnt=%0d, expected 1 0 2", pkt_end_cnt, rx_err, byte_count);
    end
  endtask

  task automatic test_seven_ones();
    start_test();
    data_bytes = '{8'h00};
    pid_fix();
    encode(0, 8'h00);
    for (int i = 0; i < 7; i++) tx_bits.push_back(1'b1);
    for (int i = 0; i < 10; i++) tx_bits.push_back(1'b0);
    load_expected(1);
    drive(1'b0, -1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL seven_ones_data: got %0d bytes, expected 1 byte %h", got_q.size(), exp_q[0]);
    end
    checks++;
    if (rx_err !== 1'b1 || pkt_end_cnt != 0) begin
      errors++; $display("FAIL seven_ones_err: got err=%b pkt_end=%0d, expected 1 and 0", rx_err, pkt_end_cnt);
    end
  endtask

  task automatic test_partial();
    start_test();
    data_bytes = '{8'($urandom_range(0, 255))};
    pid_fix();
    encode(4, 8'($urandom_range(0, 255)));
    load_expected(1);
    drive(1'b0, -1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL partial_data: got %0d bytes, expected 1 byte %h", got_q.size(), exp_q[0]);
    end
    checks++;
    if (rx_err !== 1'b1 || pkt_end_cnt != 0 || byte_count !== 11'd1) begin
      errors++;
      $display("FAIL partial_err: got err=%b pkt_end=%0d cnt=%0d, expected 1 0 1", rx_err, pkt_end_cnt, byte_count);
    end
  endtask

  task automatic test_empty_packet();
    start_test();
    data_bytes.delete();
    encode(0, 8'h00);
    drive(1'b0, -1);
    checks++;
    if (rx_err !== 1'b1 || pkt_end_cnt != 0 || got_q.size() != 0 || byte_count !== 11'd0) begin
      errors++;
      $display("FAIL empty_packet: got err=%b pkt_end=%0d bytes=%0d cnt=%0d, expected 1 0 0 0",
               rx_err, pkt_end_cnt, got_q.size(), byte_count);
    end
  endtask

  task automatic test_coincide();
    start_test();
    data_bytes = '{8'hA5};
    encode(0, 8'h00);
    drive(1'b1, -1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5 || pkt_end_cnt != 1 || rx_err !== 1'b0) begin
      errors++;
      $display("FAIL coincide: got bytes=%0d pkt_end=%0d err=%b, expected 1 byte A5, 1 pkt_end, err 0",
               got_q.size(), pkt_end_cnt, rx_err);
    end
  endtask

  task automatic test_reset_mid_packet();
    start_test();
    data_bytes = '{8'h5A};
    pid_fix();
    encode(4, 8'h0B);
    syn = 1'b1;
    tick();
    for (int i = 0; i < int'(tx_bits.size()); i++) begin
      din = tx_bits[i];
      tick();
    end
    checks++;
    if (byte_count !== 11'd1 || byte_out !== data_bytes[0]) begin
      errors++; $display("FAIL reset_mid_pre: got cnt=%0d out=%h, expected 1 %h", byte_count, byte_out, data_bytes[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({byte_out, byte_valid, byte_count, pkt_end, rx_err, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got out=%h cnt=%0d err=%b st=%0d, expected all zero",
               byte_out, byte_count, rx_err, state_dbg);
    end
    syn = 1'b0;
    din = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    start_test();
    data_bytes = '{8'h69};
    pid_fix();
    encode(0, 8'h00);
    load_expected(1);
    drive(1'b0, -1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0] || pkt_end_cnt != 1 || rx_err !== 1'b0 || byte_count !== 11'd1) begin
      errors++;
      $display("FAIL reset_mid_after: got bytes=%0d pkt_end=%0d err=%b cnt=%0d, expected 1 byte %h, 1, 0, 1",
               got_q.size(), pkt_end_cnt, rx_err, byte_count, exp_q[0]);
    end
  endtask

  task automatic test_random();
    for (int iter = 0; iter < 25; iter++) begin
      int n, k, glitch, bad;
      start_test();
      n = $urandom_range(0, 4);
      k = $urandom_range(0, 6);
      data_bytes.delete();
      for (int i = 0; i < n; i++)
        data_bytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
      pid_fix();
      encode(k, 8'($urandom_range(0, 255)));
      glitch = (tx_bits.size() > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(0, tx_bits.size() - 2) : -1;
      load_expected(n);
      exp_cnt = n;
      exp_err = (n == 0) || (k != 0);
      exp_pe  = exp_err ? 0 : 1;
      drive(1'b0, glitch);
      bad = (got_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size() && bad == 0; i++) if (got_q[i] !== exp_q[i]) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL random_data[%0d]: got %0d bytes, expected %0d", iter, got_q.size(), exp_q.size());
      end
      checks++;
      if (byte_count !== 11'(exp_cnt) || rx_err !== exp_err || pkt_end_cnt != exp_pe) begin
        errors++;
        $display("FAIL random_status[%0d]: got cnt=%0d err=%b pe=%0d, expected %0d %b %0d",
                 iter, byte_count, rx_err, pkt_end_cnt, exp_cnt, exp_err, exp_pe);
      end
    end
  endtask

  task automatic test_saturation();
    int bad;
    start_test();
    data_bytes.delete();
    for (int i = 0; i < CNT_MAX + 1; i++) data_bytes.push_back(8'($urandom_range(0, 255)));
    pid_fix();
    encode(0, 8'h00);
    load_expected(CNT_MAX + 1);
    drive(1'b0, -1);
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && bad == 0; i++) if (got_q[i] !== exp_q[i]) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL saturation_data: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end
    checks++;
    if (byte_count !== 11'(CNT_MAX) || rx_err !== 1'b1 || pkt_end_cnt != 0) begin
      errors++;
      $display("FAIL saturation_status: got cnt=%0d err=%b pe=%0d, expected %0d 1 0",
               byte_count, rx_err, pkt_end_cnt, CNT_MAX);
    end
  endtask

`ifdef RX_PID_CHECK_EN
  task automatic test_pid();
    start_test();
    data_bytes = '{8'h2D, 8'h11};
    encode(0, 8'h00);
    drive(1'b0, -1);
    checks++;
    if (rx_err !== 1'b0 || pkt_end_cnt != 1) begin
      errors++; $display("FAIL pid_good: got err=%b pe=%0d, expected 0 1", rx_err, pkt_end_cnt);
    end
    start_test();
    data_bytes = '{8'h2C, 8'h11};
    encode(0, 8'h00);
    drive(1'b0, -1);
    checks++;
    if (rx_err !== 1'b1 || pkt_end_cnt != 0 || got_q.size() != 1 || got_q[0] !== 8'h2C) begin
      errors++;
      $display("FAIL pid_bad: got err=%b pe=%0d bytes=%0d, expected 1 0 1 byte 2C", rx_err, pkt_end_cnt, got_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seven_ones();
    test_two_bytes();
    test_stuffing();
    test_partial();
    test_empty_packet();
    test_coincide();
    test_reset_mid_packet();
    test_random();
    test_saturation();
`ifdef RX_PID_CHECK_EN
    test_pid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
